// File: rtl/aven_bank_sched_pkg.sv
// Shared encodings and sizing for the noise-averaging bank sequencer.
// N_SC_DEF carries the default samples-per-symbol count.
package aven_bank_sched_pkg;

    localparam int N_SC_DEF = 64;

    localparam int N_BANK = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    function automatic logic [N_BANK-1:0] bank_onehot(input logic [1:0] idx);
        return N_BANK'(1) << idx;
    endfunction

endpackage

// File: rtl/aven_bank_sched.sv
// Steers four consecutive N_SC-sample symbols into four bank FIFOs, then reads
// all banks in lockstep so the averaging adder tree sees aligned operands.
module aven_bank_sched
    import aven_bank_sched_pkg::*;
#(
    parameter int N_SC  = N_SC_DEF,
    parameter int CNT_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_din_vld,
    input  logic [N_BANK-1:0] i_bank_full,
    input  logic [N_BANK-1:0] i_bank_empty,
    output logic [N_BANK-1:0] o_bank_wr_en,
    output logic              o_bank_rd_en,
    output logic              o_bank_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_ovf,
    output logic              o_err_abort
);

    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(N_SC - 1);
    localparam logic [CNT_W-1:0] SC_FULL = CNT_W'(N_SC);
    localparam logic [1:0]       SYM_LAST = 2'(N_BANK - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_sc_cnt;
    logic [1:0]         r_sym_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;

    logic [N_BANK-1:0]  r_wr_en;
    logic               r_rd_en;
    logic               r_flush;
    logic               r_done;
    logic               r_err_ovf;
    logic               r_err_abort;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_sc_nxt;
    logic [1:0]         w_sym_nxt;
    logic [CNT_W-1:0]   w_rd_cnt_nxt;
    logic [N_BANK-1:0]  w_wr_nxt;
    logic               w_rd_nxt;
    logic               w_flush_nxt;
    logic               w_done_nxt;
    logic               w_ovf_nxt;
    logic               w_abort_nxt;
    logic               w_sample;
    logic               w_go_abort;

    always_comb begin
        w_state_nxt  = r_state;
        w_sc_nxt     = r_sc_cnt;
        w_sym_nxt    = r_sym_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        w_wr_nxt     = '0;
        w_rd_nxt     = 1'b0;
        w_flush_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_ovf_nxt    = r_err_ovf;
        w_abort_nxt  = r_err_abort;
        w_sample     = 1'b0;
        w_go_abort   = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_done_nxt = (r_state == ST_DONE);
                if (i_frame_start) begin
                    // Accepting a frame clears history; a same-cycle strobe is sample 0 of bank 0.
                    w_state_nxt  = ST_FILL;
                    w_sc_nxt     = '0;
                    w_sym_nxt    = '0;
                    w_rd_cnt_nxt = '0;
                    w_ovf_nxt    = 1'b0;
                    w_abort_nxt  = 1'b0;
                    w_sample     = i_din_vld;
                end else begin
                    w_state_nxt = ST_IDLE;
                    if (i_din_vld) w_ovf_nxt = 1'b1;
                end
            end
            ST_FILL: begin
                if (i_frame_start) w_go_abort = 1'b1;
                else               w_sample   = i_din_vld;
            end
            ST_DRAIN: begin
                if (i_frame_start) begin
                    w_go_abort = 1'b1;
                end else begin
                    if (i_din_vld) w_ovf_nxt = 1'b1;
                    // Read only when every bank can supply an operand, keeping the banks in lockstep.
                    if (!(|i_bank_empty) && (r_rd_cnt < SC_FULL)) begin
                        w_rd_nxt     = 1'b1;
                        w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                        if (r_rd_cnt == SC_LAST) w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
                if (i_din_vld) w_ovf_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_go_abort) begin
            w_state_nxt  = ST_ABORT;
            w_flush_nxt  = 1'b1;
            w_abort_nxt  = 1'b1;
            w_sc_nxt     = '0;
            w_sym_nxt    = '0;
            w_rd_cnt_nxt = '0;
        end

        if (w_sample) begin
            if (i_bank_full[w_sym_nxt]) w_ovf_nxt = 1'b1;
            else                        w_wr_nxt  = bank_onehot(w_sym_nxt);
            if (w_sc_nxt == SC_LAST) begin
                w_sc_nxt = '0;
                if (w_sym_nxt == SYM_LAST) w_state_nxt = ST_DRAIN;
                else                       w_sym_nxt   = w_sym_nxt + 1'b1;
            end else begin
                w_sc_nxt = w_sc_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_sc_cnt  <= '0;
            r_sym_cnt <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sc_cnt  <= w_sc_nxt;
            r_sym_cnt <= w_sym_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
        end
    end

    // Registered strobes land one cycle after the decision, matching the external data delay.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en     <= '0;
            r_rd_en     <= 1'b0;
            r_flush     <= 1'b0;
            r_done      <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_wr_en     <= w_wr_nxt;
            r_rd_en     <= w_rd_nxt;
            r_flush     <= w_flush_nxt;
            r_done      <= w_done_nxt;
            r_err_ovf   <= w_ovf_nxt;
            r_err_abort <= w_abort_nxt;
        end
    end

    assign o_bank_wr_en = r_wr_en;
    assign o_bank_rd_en = r_rd_en;
    assign o_bank_flush = r_flush;
    assign o_busy       = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign o_done       = r_done;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_abort  = r_err_abort;

endmodule

// File: tb/tb_aven_bank_sched.sv
// Directed bench for aven_bank_sched with N_SC=64: full frames, read stalls,
// full-bank drops, abort, async reset and stray strobes.
module tb_aven_bank_sched;
    import aven_bank_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       din_vld;
    logic [3:0] bank_full;
    logic [3:0] bank_empty;
    logic [3:0] wr_en;
    logic       rd_en;
    logic       flush;
    logic       busy;
    logic       done;
    logic       err_ovf;
    logic       err_abort;

    aven_bank_sched #(.N_SC(64), .CNT_W(12)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_din_vld     (din_vld),
        .i_bank_full   (bank_full),
        .i_bank_empty  (bank_empty),
        .o_bank_wr_en  (wr_en),
        .o_bank_rd_en  (rd_en),
        .o_bank_flush  (flush),
        .o_busy        (busy),
        .o_done        (done),
        .o_err_ovf     (err_ovf),
        .o_err_abort   (err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) if (v[b]) r = b;
        return r;
    endfunction

    logic mon_clr = 1'b0;
    int   wr_cnt [4];
    int   wr_seq [256];
    int   wr_total, rd_total, done_cnt, flush_cnt, onehot_err;
    int   first_wr, first_rd, last_rd, done_cyc;

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int b = 0; b < 4; b++) wr_cnt[b] <= 0;
            for (int s = 0; s < 256; s++) wr_seq[s] <= -1;
            wr_total <= 0; rd_total <= 0; done_cnt <= 0; flush_cnt <= 0; onehot_err <= 0;
            first_wr <= -1; first_rd <= -1; last_rd <= -1; done_cyc <= -1;
        end else begin
            if (|wr_en) begin
                if (wr_total < 256) wr_seq[wr_total] <= oh2idx(wr_en);
                wr_total <= wr_total + 1;
                wr_cnt[oh2idx(wr_en)] <= wr_cnt[oh2idx(wr_en)] + 1;
                if (first_wr < 0) first_wr <= cyc;
            end
            if ($countones(wr_en) > 1) onehot_err <= onehot_err + 1;
            if (rd_en) begin
                rd_total <= rd_total + 1;
                if (first_rd < 0) first_rd <= cyc;
                last_rd <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (flush) flush_cnt <= flush_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    int c_first, c_last;

    // Drives n contiguous strobes, frame_start on the first; bank_full uses fmask on samples [flo,fhi).
    task automatic run_samples(input int n, input int flo, input int fhi, input logic [3:0] fmask);
        for (int i = 0; i < n; i++) begin
            frame_start = (i == 0);
            din_vld     = 1'b1;
            bank_full   = (i >= flo && i < fhi) ? fmask : 4'b0000;
            if (i == 0)     c_first = cyc;
            if (i == n - 1) c_last  = cyc;
            tick();
        end
        frame_start = 1'b0;
        din_vld     = 1'b0;
        bank_full   = 4'b0000;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, int'(done), 1);
        tick();
        check({tag, "_done_1cyc"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    int hold_bad;

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; din_vld = 1'b0;
        bank_full = 4'b0000; bank_empty = 4'b0000;
        repeat (3) tick();
        check("reset_outputs", int'({wr_en, rd_en, flush, busy, done, err_ovf, err_abort}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full frame, contiguous strobes, banks never empty.
        clear_mon();
        run_samples(256, 0, 0, 4'b0000);
        check("t2_busy_drain", int'(busy), 1);
        wait_done(200, "t2");
        check("t2_wr_b0", wr_cnt[0], 64);
        check("t2_wr_b1", wr_cnt[1], 64);
        check("t2_wr_b2", wr_cnt[2], 64);
        check("t2_wr_b3", wr_cnt[3], 64);
        check("t2_seq_0", wr_seq[0], 0);
        check("t2_seq_63", wr_seq[63], 0);
        check("t2_seq_64", wr_seq[64], 1);
        check("t2_seq_191", wr_seq[191], 2);
        check("t2_seq_255", wr_seq[255], 3);
        check("t2_wr_latency", first_wr - c_first, 1);
        check("t2_rd_latency", first_rd - c_last, 2);
        check("t2_rd_total", rd_total, 64);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_latency", done_cyc - last_rd, 1);
        check("t2_onehot", onehot_err, 0);
        check("t2_err_ovf", int'(err_ovf), 0);

        // Bank 2 runs dry for five cycles mid-drain.
        clear_mon();
        run_samples(256, 0, 0, 4'b0000);
        repeat (10) tick();
        bank_empty = 4'b0100;
        hold_bad = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (rd_en) hold_bad++;
        end
        check("t3_rd_held", hold_bad, 0);
        bank_empty = 4'b0000;
        wait_done(200, "t3");
        check("t3_rd_total", rd_total, 64);
        check("t3_done_latency", done_cyc - last_rd, 1);

        // Bank 1 full for the whole of symbol 1.
        clear_mon();
        run_samples(256, 64, 128, 4'b0010);
        check("t4_err_ovf", int'(err_ovf), 1);
        check("t4_busy_drain", int'(busy), 1);
        wait_done(200, "t4");
        check("t4_wr_b0", wr_cnt[0], 64);
        check("t4_wr_b1", wr_cnt[1], 0);
        check("t4_wr_b3", wr_cnt[3], 64);
        check("t4_rd_total", rd_total, 64);

        // Abort at sample 100.
        clear_mon();
        run_samples(100, 0, 0, 4'b0000);
        check("t5_ovf_cleared", int'(err_ovf), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_flush", int'(flush), 1);
        check("t5_err_abort", int'(err_abort), 1);
        check("t5_busy_abort", int'(busy), 0);
        check("t5_wr_zero", int'(wr_en), 0);
        tick();
        check("t5_flush_1cyc", int'(flush), 0);
        check("t5_idle_busy", int'(busy), 0);
        check("t5_flush_cnt", flush_cnt, 1);
        check("t5_no_done", done_cnt, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_abort_cleared", int'(err_abort), 0);
        check("t5_rearm_busy", int'(busy), 1);

        // Async reset while filling.
        for (int i = 0; i < 10; i++) begin
            din_vld = 1'b1;
            tick();
        end
        check("t1_wr_before_rst", int'(wr_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        din_vld = 1'b0;
        check("t1_async_outputs", int'({wr_en, rd_en, flush, busy, done, err_ovf, err_abort}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t1_idle_after_rst", int'(busy), 0);

        // Stray strobe in IDLE.
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        check("t6_no_wr", int'(wr_en), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_err_ovf", int'(err_ovf), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_ovf_cleared", int'(err_ovf), 0);
        check("t6_armed", int'(busy), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
